// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM write-master state type, burst/address types and bus widths
package sdram_pkg;
  localparam int SDRAM_DQ_WIDTH    = 16;
  localparam int SDRAM_ADDR_WIDTH  = 24;
  localparam int SDRAM_BURST_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_WAIT_FIN
  } wr_state_t;

  typedef logic [SDRAM_BURST_WIDTH-1:0] burst_len_t;
  typedef logic [SDRAM_ADDR_WIDTH-1:0]  sdram_addr_t;
endpackage

// File: rtl/sdram_wr_burst_master_if.sv
// rtl/sdram_wr_burst_master_if.sv - stream input and SDRAM write-burst signals of sdram_wr_burst_master
interface sdram_wr_burst_master_if
  import sdram_pkg::*;
#(
  parameter int DQ_WIDTH    = SDRAM_DQ_WIDTH,
  parameter int ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
  parameter int BURST_WIDTH = SDRAM_BURST_WIDTH,
  parameter int FIFO_DEPTH  = 512
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                   s_valid;
  logic                   s_ready;
  logic [DQ_WIDTH-1:0]    s_data;
  logic                   wr_req;
  logic [BURST_WIDTH-1:0] wr_len;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DQ_WIDTH-1:0]    wr_data;
  logic                   wr_valid;
  logic                   wr_finish;
  logic                   busy;
  logic [LEVEL_W-1:0]     level;
  logic                   underrun_err;

  modport master (
    input  s_valid, s_data, wr_valid, wr_finish,
    output s_ready, wr_req, wr_len, wr_addr, wr_data, busy, level, underrun_err
  );

  modport slave (
    output s_valid, s_data, wr_valid, wr_finish,
    input  s_ready, wr_req, wr_len, wr_addr, wr_data, busy, level, underrun_err
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, registered read port (1-cycle latency, holds between reads), level count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = rd_data_q;
  assign level   = count_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + LW'(do_wr) - LW'(do_rd);
    end
  end
endmodule

// File: rtl/sdram_wr_burst_master.sv
// rtl/sdram_wr_burst_master.sv - stages a word stream and issues SDRAM write bursts over a wrapping region
// Optional partial-burst flush port enabled by SDRAM_WR_FLUSH_EN.
module sdram_wr_burst_master
  import sdram_pkg::*;
#(
  parameter int DQ_WIDTH     = SDRAM_DQ_WIDTH,
  parameter int ADDR_WIDTH   = SDRAM_ADDR_WIDTH,
  parameter int BURST_WIDTH  = SDRAM_BURST_WIDTH,
  parameter int BURST_LEN    = 256,
  parameter int FIFO_DEPTH   = 512,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 1 << 20
) (
  input logic clk,
  input logic rst_n,
`ifdef SDRAM_WR_FLUSH_EN
  input logic flush,
`endif
  sdram_wr_burst_master_if.master bus
);
  localparam int                     LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0]  BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]    REGION   = (ADDR_WIDTH + 1)'(REGION_WORDS);
  localparam logic [BURST_WIDTH-1:0] FULL_LEN = BURST_WIDTH'(BURST_LEN);
  localparam logic [LEVEL_W-1:0]     FULL_LVL = LEVEL_W'(BURST_LEN);
  localparam logic [BURST_WIDTH-1:0] ONE      = BURST_WIDTH'(1);

  wr_state_t              state_q;
  logic                   wr_req_q, underrun_q;
  logic [BURST_WIDTH-1:0] wr_len_q, pop_cnt_q, pop_cnt_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]    next_off;
  logic [LEVEL_W-1:0]     level;
  logic                   fifo_full, fifo_empty, push, pop, last_pop;
  logic                   in_burst, want_word, burst_ready, start_partial;

  assign bus.s_ready = rst_n && !fifo_full;
  assign push        = bus.s_valid && bus.s_ready;
  assign in_burst    = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign want_word   = in_burst && bus.wr_valid && (pop_cnt_q != wr_len_q);
  assign pop         = want_word && !fifo_empty;
  assign pop_cnt_d   = pop_cnt_q + ONE;
  assign last_pop    = pop && (pop_cnt_d == wr_len_q);
  assign burst_ready = (level >= FULL_LVL);

`ifdef SDRAM_WR_FLUSH_EN
  assign start_partial = flush && (level != '0) && !burst_ready;
`else
  assign start_partial = 1'b0;
`endif

  // Offset arithmetic is one bit wider so a region ending at the top of the address space still wraps.
  assign next_off  = (ADDR_WIDTH + 1)'(wr_addr_q - BASE) + (ADDR_WIDTH + 1)'(wr_len_q);
  assign wr_addr_d = (next_off >= REGION) ? BASE : BASE + next_off[ADDR_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (DQ_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (bus.s_data),
    .rd_en   (pop),
    .rd_data (bus.wr_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_req_q   <= 1'b0;
      wr_len_q   <= '0;
      wr_addr_q  <= BASE;
      pop_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (want_word && fifo_empty) underrun_q <= 1'b1;
      if (pop) pop_cnt_q <= pop_cnt_d;
      if ((state_q != ST_IDLE) && bus.wr_finish) begin
        state_q   <= ST_IDLE;
        wr_req_q  <= 1'b0;
        wr_addr_q <= wr_addr_d;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (burst_ready || start_partial) begin
              state_q   <= ST_REQ;
              wr_req_q  <= 1'b1;
              wr_len_q  <= burst_ready ? FULL_LEN : BURST_WIDTH'(level);
              pop_cnt_q <= '0;
            end
          end
          ST_REQ: begin
            if (bus.wr_valid) state_q <= last_pop ? ST_WAIT_FIN : ST_DATA;
          end
          ST_DATA: begin
            if (last_pop) state_q <= ST_WAIT_FIN;
          end
          ST_WAIT_FIN: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_req       = wr_req_q;
  assign bus.wr_len       = wr_len_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.level        = level;
  assign bus.underrun_err = underrun_q;
endmodule

// File: tb/tb_sdram_wr_burst_master.sv
// tb/tb_sdram_wr_burst_master.sv - directed bench; dut_a uses the default region, dut_b a 512-word region
module tb_sdram_wr_burst_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_finish = 1'b0;
`ifdef SDRAM_WR_FLUSH_EN
  logic        flush = 1'b0;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_wr_burst_master_if bus_a ();
  sdram_wr_burst_master_if bus_b ();

  assign bus_a.s_valid   = s_valid;
  assign bus_a.s_data    = s_data;
  assign bus_a.wr_valid  = wr_valid;
  assign bus_a.wr_finish = wr_finish;
  assign bus_b.s_valid   = s_valid;
  assign bus_b.s_data    = s_data;
  assign bus_b.wr_valid  = wr_valid;
  assign bus_b.wr_finish = wr_finish;

  sdram_wr_burst_master dut_a (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SDRAM_WR_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus_a)
  );

  sdram_wr_burst_master #(.REGION_WORDS(512)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SDRAM_WR_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; wr_valid = 1'b0; wr_finish = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_words(input int count, input int first);
    for (int i = 0; i < count; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(first + i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int cyc = 0;
    while (bus_a.wr_req !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    ok = (bus_a.wr_req === 1'b1);
  endtask

  task automatic finish_burst();
    wr_valid  = 1'b0;
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus_a.s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", bus_a.s_ready); end
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req: got %b want 0", bus_a.wr_req); end
    n_cmp++; if (bus_a.wr_len !== 9'd0) begin n_err++; $display("FAIL reset_wr_len: got %0d want 0", bus_a.wr_len); end
    n_cmp++; if (bus_a.wr_addr !== 24'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0h want 0", bus_a.wr_addr); end
    n_cmp++; if (bus_a.wr_data !== 16'd0) begin n_err++; $display("FAIL reset_wr_data: got %0h want 0", bus_a.wr_data); end
    n_cmp++; if (bus_a.level !== 10'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus_a.level); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.underrun_err !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", bus_a.underrun_err); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus_a.s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_ready: got %b want 1", bus_a.s_ready); end
  endtask

  task automatic test_single_burst();
    bit ok;
    push_words(256, 0);
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_req: got timeout want wr_req"); end
    n_cmp++; if (bus_a.wr_addr !== 24'd0) begin n_err++; $display("FAIL single_addr: got %0d want 0", bus_a.wr_addr); end
    n_cmp++; if (bus_a.wr_len !== 9'd256) begin n_err++; $display("FAIL single_len: got %0d want 256", bus_a.wr_len); end
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus_a.busy); end
    for (int i = 0; i < 256; i++) begin
      wr_valid = 1'b1;
      tick();
      n_cmp++;
      if (bus_a.wr_data !== 16'(i)) begin n_err++; $display("FAIL single_data[%0d]: got %0h want %0h", i, bus_a.wr_data, 16'(i)); end
    end
    wr_valid = 1'b0;
    n_cmp++; if (bus_a.level !== 10'd0) begin n_err++; $display("FAIL single_level: got %0d want 0", bus_a.level); end
    n_cmp++; if (bus_a.wr_req !== 1'b1) begin n_err++; $display("FAIL single_req_held: got %b want 1", bus_a.wr_req); end
    finish_burst();
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL single_req_drop: got %b want 0", bus_a.wr_req); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", bus_a.busy); end
    tick(); tick();
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL single_no_rereq: got %b want 0", bus_a.wr_req); end
  endtask

  task automatic test_extra_valid();
    bit ok;
    do_reset();
    push_words(300, 0);
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL extra_req: got timeout want wr_req"); end
    for (int i = 0; i < 257; i++) begin
      wr_valid = 1'b1;
      tick();
      if (i < 256) begin
        n_cmp++;
        if (bus_a.wr_data !== 16'(i)) begin n_err++; $display("FAIL extra_data[%0d]: got %0h want %0h", i, bus_a.wr_data, 16'(i)); end
      end
    end
    wr_valid = 1'b0;
    n_cmp++; if (bus_a.wr_data !== 16'd255) begin n_err++; $display("FAIL extra_hold: got %0h want ff", bus_a.wr_data); end
    n_cmp++; if (bus_a.level !== 10'd44) begin n_err++; $display("FAIL extra_level: got %0d want 44", bus_a.level); end
    n_cmp++; if (bus_a.underrun_err !== 1'b0) begin n_err++; $display("FAIL extra_underrun: got %b want 0", bus_a.underrun_err); end
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL extra_busy: got %b want 1", bus_a.busy); end
    finish_burst();
    tick();
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL extra_no_partial: got %b want 0", bus_a.wr_req); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      begin
        int n = 0;
        int guard = 0;
        logic rdy;
        while (n < 1024 && guard < 20000) begin
          s_valid = 1'b1;
          s_data  = 16'(n);
          rdy     = bus_a.s_ready;
          tick();
          if (rdy) n++;
          guard++;
        end
        s_valid = 1'b0;
      end
      begin
        int exp_word = 0;
        for (int b = 0; b < 4; b++) begin
          bit ok;
          int got = 0;
          int cyc = 0;
          wait_req(ok);
          n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_req[%0d]: got timeout want wr_req", b); end
          n_cmp++; if (bus_a.wr_addr !== 24'(256 * b)) begin n_err++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", b, bus_a.wr_addr, 256 * b); end
          n_cmp++; if (bus_b.wr_addr !== 24'(256 * (b % 2))) begin n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", b, bus_b.wr_addr, 256 * (b % 2)); end
          n_cmp++; if (bus_a.wr_len !== 9'd256) begin n_err++; $display("FAIL b2b_len[%0d]: got %0d want 256", b, bus_a.wr_len); end
          while (got < 256 && cyc < 4000) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            wr_valid = v;
            tick();
            cyc++;
            if (v) begin
              n_cmp++;
              if (bus_a.wr_data !== 16'(exp_word) || bus_b.wr_data !== 16'(exp_word)) begin
                n_err++;
                $display("FAIL b2b_data[%0d]: got %0h/%0h want %0h", exp_word, bus_a.wr_data, bus_b.wr_data, 16'(exp_word));
              end
              exp_word++;
              got++;
            end
          end
          finish_burst();
          n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL b2b_gap[%0d]: got %b want 0", b, bus_a.wr_req); end
        end
      end
    join
    n_cmp++; if (bus_a.underrun_err !== 1'b0 || bus_b.underrun_err !== 1'b0) begin n_err++; $display("FAIL b2b_underrun: got %b/%b want 0", bus_a.underrun_err, bus_b.underrun_err); end
    n_cmp++; if (bus_a.level !== 10'd0) begin n_err++; $display("FAIL b2b_level: got %0d want 0", bus_a.level); end
  endtask

  task automatic test_underrun();
    bit ok;
    do_reset();
    push_words(200, 0);
    force dut_a.burst_ready = 1'b1;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL under_req: got timeout want wr_req"); end
    n_cmp++; if (bus_a.wr_len !== 9'd256) begin n_err++; $display("FAIL under_len: got %0d want 256", bus_a.wr_len); end
    for (int i = 0; i < 200; i++) begin
      wr_valid = 1'b1;
      tick();
      n_cmp++;
      if (bus_a.wr_data !== 16'(i)) begin n_err++; $display("FAIL under_data[%0d]: got %0h want %0h", i, bus_a.wr_data, 16'(i)); end
    end
    n_cmp++; if (bus_a.underrun_err !== 1'b0) begin n_err++; $display("FAIL under_early: got %b want 0", bus_a.underrun_err); end
    tick();
    n_cmp++; if (bus_a.underrun_err !== 1'b1) begin n_err++; $display("FAIL under_set: got %b want 1", bus_a.underrun_err); end
    n_cmp++; if (bus_a.wr_data !== 16'd199) begin n_err++; $display("FAIL under_hold: got %0d want 199", bus_a.wr_data); end
    finish_burst();
    release dut_a.burst_ready;
    tick();
    n_cmp++; if (bus_a.underrun_err !== 1'b1) begin n_err++; $display("FAIL under_sticky: got %b want 1", bus_a.underrun_err); end
    do_reset();
    n_cmp++; if (bus_a.underrun_err !== 1'b0) begin n_err++; $display("FAIL under_clear: got %b want 0", bus_a.underrun_err); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    push_words(256, 0);
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_req: got timeout want wr_req"); end
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop: got %b want 0", bus_a.wr_req); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.level !== 10'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", bus_a.level); end
    n_cmp++; if (bus_a.wr_data !== 16'd0) begin n_err++; $display("FAIL mid_data: got %0h want 0", bus_a.wr_data); end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (bus_a.wr_req !== 1'b0) begin n_err++; $display("FAIL mid_no_resume: got %b want 0", bus_a.wr_req); end
    n_cmp++; if (bus_a.wr_addr !== 24'd0) begin n_err++; $display("FAIL mid_addr: got %0d want 0", bus_a.wr_addr); end
  endtask

`ifdef SDRAM_WR_FLUSH_EN
  task automatic test_flush();
    bit ok;
    do_reset();
    push_words(10, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL flush_req: got timeout want wr_req"); end
    n_cmp++; if (bus_a.wr_len !== 9'd10) begin n_err++; $display("FAIL flush_len: got %0d want 10", bus_a.wr_len); end
    n_cmp++; if (bus_a.wr_addr !== 24'd0) begin n_err++; $display("FAIL flush_addr: got %0d want 0", bus_a.wr_addr); end
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      tick();
      n_cmp++;
      if (bus_a.wr_data !== 16'(i)) begin n_err++; $display("FAIL flush_data[%0d]: got %0h want %0h", i, bus_a.wr_data, 16'(i)); end
    end
    finish_burst();
    push_words(256, 100);
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL flush_req2: got timeout want wr_req"); end
    n_cmp++; if (bus_a.wr_addr !== 24'd10) begin n_err++; $display("FAIL flush_next_addr: got %0d want 10", bus_a.wr_addr); end
    n_cmp++; if (bus_a.wr_len !== 9'd256) begin n_err++; $display("FAIL flush_next_len: got %0d want 256", bus_a.wr_len); end
    finish_burst();
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    #3;
    test_reset();
    test_single_burst();
    test_extra_valid();
    test_back_to_back();
    test_underrun();
    test_reset_mid_burst();
`ifdef SDRAM_WR_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion want summary before 900000ns");
    $fatal(1);
  end
endmodule
